// File: rtl/seq_detect_param_if.sv
// Bus bundle for the parametrised serial pattern detector.
// Optional macro SEQ_DETECT_MASK_EN adds the cfg_mask signal.
interface seq_detect_param_if #(
  parameter int PAT_W = 5,
  parameter int CNT_W = 8
);
  localparam int FILL_W = $clog2(PAT_W + 1);

  logic              en;
  logic              data_vld;
  logic              data_in;
  logic              ovl_en;
  logic              cfg_we;
  logic [PAT_W-1:0]  cfg_pattern;
`ifdef SEQ_DETECT_MASK_EN
  logic [PAT_W-1:0]  cfg_mask;
`endif
  logic              clr_cnt;
  logic              find_ok;
  logic [CNT_W-1:0]  match_cnt;
  logic [FILL_W-1:0] fill_cnt;

  modport master (
    output en, data_vld, data_in, ovl_en, cfg_we, cfg_pattern,
`ifdef SEQ_DETECT_MASK_EN
    output cfg_mask,
`endif
    output clr_cnt,
    input  find_ok, match_cnt, fill_cnt
  );

  modport slave (
    input  en, data_vld, data_in, ovl_en, cfg_we, cfg_pattern,
`ifdef SEQ_DETECT_MASK_EN
    input  cfg_mask,
`endif
    input  clr_cnt,
    output find_ok, match_cnt, fill_cnt
  );
endinterface

// File: rtl/seq_detect_param.sv
// Serial bit-pattern detector with run-time pattern, overlap mode and saturating match counter.
// Optional macro SEQ_DETECT_MASK_EN enables a per-bit don't-care mask loaded with the pattern.
module seq_detect_param #(
  parameter int               PAT_W    = 5,
  parameter logic [PAT_W-1:0] PAT_INIT = 5'b10010,
  parameter int               CNT_W    = 8
) (
  input logic               clk,
  input logic               rst_n,
  seq_detect_param_if.slave bus
);
  localparam int                FILL_W   = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_CMP = FILL_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  // Only the newest PAT_W-1 bits are stored; the incoming bit completes the window.
  logic [PAT_W-2:0]  hist_q, hist_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              find_q, find_d;
`ifdef SEQ_DETECT_MASK_EN
  logic [PAT_W-1:0]  mask_q, mask_d;
`endif

  logic [PAT_W-1:0] window;
  logic             accept;
  logic             bits_eq;
  logic             match;

  always_comb begin
    // NOTE: every variable gets a default first so no latch can be inferred.
    window  = {hist_q, bus.data_in};
    accept  = bus.en && bus.data_vld && !bus.cfg_we;
`ifdef SEQ_DETECT_MASK_EN
    bits_eq = ((window ^ pat_q) & mask_q) == '0;
`else
    bits_eq = (window == pat_q);
`endif
    match   = accept && bits_eq && (fill_q >= FILL_CMP);

    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;
    find_d = match;
`ifdef SEQ_DETECT_MASK_EN
    mask_d = mask_q;
`endif

    if (bus.cfg_we) begin
      pat_d  = bus.cfg_pattern;
`ifdef SEQ_DETECT_MASK_EN
      mask_d = bus.cfg_mask;
`endif
      hist_d = '0;
      fill_d = '0;
    end else if (accept) begin
      hist_d = window[PAT_W-2:0];
      // Non-overlapping mode restarts the fill so the next match needs PAT_W fresh bits.
      if (match && !bus.ovl_en)
        fill_d = '0;
      else if (fill_q != FILL_MAX)
        fill_d = fill_q + FILL_W'(1);
    end

    if (bus.clr_cnt)
      cnt_d = '0;
    else if (match && cnt_q != CNT_MAX)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q  <= PAT_INIT;
      hist_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
      find_q <= 1'b0;
`ifdef SEQ_DETECT_MASK_EN
      mask_q <= '1;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
      find_q <= find_d;
`ifdef SEQ_DETECT_MASK_EN
      mask_q <= mask_d;
`endif
    end
  end

  assign bus.find_ok   = find_q;
  assign bus.match_cnt = cnt_q;
  assign bus.fill_cnt  = fill_q;
endmodule
